alu_seq_param: RTL

Parametrised, registered successor to the team's 8-bit ALU. Adds WIDTH generalisation, valid/ready handshakes on input and output, a status-flag set, and a multi-cycle unsigned shift-add multiplier. Sits between the operand/decode stage and the writeback register file. The output register holds its result under backpressure.

---
 rtl/alu_seq_param_if.sv | 31 +++
 rtl/alu_seq_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_param_if.sv
// Request/response bundle between the operand/decode stage and alu_seq_param.
// The master drives operation requests and consumes results; the ALU is the slave.
interface alu_seq_param_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [3:0]       opcode;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] outQ;
  logic [WIDTH-1:0] outQ_hi;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, opA, opB, opcode, cin, out_ready,
    input  in_ready, out_valid, outQ, outQ_hi, cout, zero, neg, ovf, busy
  );

  modport slave (
    input  in_valid, opA, opB, opcode, cin, out_ready,
    output in_ready, out_valid, outQ, outQ_hi, cout, zero, neg, ovf, busy
  );
endinterface

// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with valid/ready handshakes, status flags and a
// multi-cycle unsigned shift-add multiplier; the result register holds under backpressure.
module alu_seq_param #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  alu_seq_param_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LSH  = 4'h2;
  localparam logic [3:0] OP_RSH  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_NAND = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_NOR  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             c;
    logic             v;
  } res_t;

  // Single-cycle operations; unknown opcodes (including MUL here) yield all zeros.
  function automatic res_t alu_op(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic ci);
    res_t                    r;
    logic [WIDTH:0]          sum;
    logic signed [WIDTH-1:0] as;
    logic signed [WIDTH-1:0] bs;
    logic signed [WIDTH-1:0] rs;
    r   = '0;
    sum = '0;
    as  = signed'(a);
    bs  = signed'(b);
    rs  = '0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
        r.q = sum[WIDTH-1:0];
        r.c = sum[WIDTH];
        rs  = signed'(r.q);
        r.v = ((as < 0) == (bs < 0)) && ((rs < 0) != (as < 0));
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ci};
        r.q = sum[WIDTH-1:0];
        r.c = sum[WIDTH];
        rs  = signed'(r.q);
        r.v = ((as < 0) != (bs < 0)) && ((rs < 0) != (as < 0));
      end
      OP_LSH: begin
        r.q = {a[WIDTH-2:0], ci};
        r.c = a[WIDTH-1];
      end
      OP_RSH: begin
        r.q = {ci, a[WIDTH-1:1]};
        r.c = a[0];
      end
      OP_XOR:  r.q = a ^ b;
      OP_AND:  r.q = a & b;
      OP_NAND: r.q = ~(a & b);
      OP_OR:   r.q = a | b;
      OP_NOR:  r.q = ~(a | b);
      OP_CMP: begin
        if (a == b)     r.q = WIDTH'(1);
        else if (a > b) r.q = WIDTH'(2);
        else            r.q = WIDTH'(3);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  state_t             state;
  state_t             state_d;
  logic               in_ready;
  logic               accept;
  logic               is_mul;
  logic               out_free;
  logic               mul_done;
  logic               load_single;
  logic               load_mul;
  res_t               res;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;

  logic               vld_p1;
  logic [WIDTH-1:0]   q_p1;
  logic [WIDTH-1:0]   q_hi_p1;
  logic               cout_p1;
  logic               ovf_p1;

  assign res      = alu_op(bus.opcode, bus.opA, bus.opB, bus.cin);
  assign is_mul   = MUL_EN && (bus.opcode == OP_MUL);
  assign out_free = !vld_p1 || bus.out_ready;
  assign in_ready = (state == IDLE) && out_free;
  assign accept   = bus.in_valid && in_ready;

  // One shift-add step per edge; once cnt reaches WIDTH the product sits in acc.
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign prod     = (cnt == CW'(WIDTH)) ? acc : acc_nxt;
  assign mul_done = (cnt == CW'(WIDTH - 1)) || (cnt == CW'(WIDTH));

  always_comb begin
    state_d     = state;
    load_single = 1'b0;
    load_mul    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) state_d = MUL_RUN;
          else        load_single = 1'b1;
        end
      end
      MUL_RUN: begin
        if (mul_done && out_free) begin
          load_mul = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if (accept && is_mul) begin
        cnt <= '0;
      end else if ((state == MUL_RUN) && (cnt != CW'(WIDTH))) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Multiplier datapath: operands captured at acceptance, then iterated.
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.opA};
      mplier <= bus.opB;
    end else if ((state == MUL_RUN) && (cnt != CW'(WIDTH))) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Stage p1: result and flag register presented to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      q_p1    <= '0;
      q_hi_p1 <= '0;
      cout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else if (load_single) begin
      vld_p1  <= 1'b1;
      q_p1    <= res.q;
      q_hi_p1 <= '0;
      cout_p1 <= res.c;
      ovf_p1  <= res.v;
    end else if (load_mul) begin
      vld_p1  <= 1'b1;
      q_p1    <= prod[WIDTH-1:0];
      q_hi_p1 <= prod[2*WIDTH-1:WIDTH];
      cout_p1 <= |prod[2*WIDTH-1:WIDTH];
      ovf_p1  <= 1'b0;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.busy      = (state == MUL_RUN);
  assign bus.out_valid = vld_p1;
  assign bus.outQ      = q_p1;
  assign bus.outQ_hi   = q_hi_p1;
  assign bus.cout      = cout_p1;
  assign bus.ovf       = ovf_p1;
  assign bus.zero      = (q_p1 == '0);
  assign bus.neg       = q_p1[WIDTH-1];

endmodule
